// File: rtl/shift_frame_if.sv
// Bundle between the serial front end, the external shift register and the byte consumer.
// serial_valid qualifies serial_data; there is no backpressure, so every valid bit is accepted and shifted in the cycle it is presented.
interface shift_frame_if;
  logic       serial_valid;
  logic       serial_data;
  logic [7:0] parallel_data;
  logic       shift_ena;
  logic       byte_valid;
  logic [7:0] byte_idx;
  logic       frame_done;
  logic       frame_abort;
  logic       frame_err;
  logic       busy;
  logic [1:0] state_dbg;

  modport master (
    output serial_valid, serial_data, parallel_data,
    input  shift_ena, byte_valid, byte_idx, frame_done, frame_abort, frame_err, busy, state_dbg
  );

  modport slave (
    input  serial_valid, serial_data, parallel_data,
    output shift_ena, byte_valid, byte_idx, frame_done, frame_abort, frame_err, busy, state_dbg
  );
endinterface

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer for an external serial-to-parallel shift register: header hunt, byte strobes, timeout abort.
// Optional trailing XOR checksum byte enabled by defining SHIFT_FRAME_CHECKSUM_EN.
module shift_frame_ctrl #(
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter int         NUM_BYTES = 4,
  parameter int         TIMEOUT   = 64
) (
  input  logic         clk,
  input  logic         reset,
  shift_frame_if.slave bus
);
  localparam int IW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CKSUM   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    hunt_cnt_q, hunt_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_idx_q, byte_idx_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_abort_q, frame_abort_d;
  logic [7:0]    window;
  logic          last_byte;
`ifdef SHIFT_FRAME_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
  logic          frame_err_q, frame_err_d;
`endif

  // window is what the shift register will hold after this cycle's valid bit
  assign window    = {bus.parallel_data[6:0], bus.serial_data};
  assign last_byte = (byte_cnt_q == 8'(NUM_BYTES - 1));

  always_comb begin
    state_d       = state_q;
    hunt_cnt_d    = hunt_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    byte_valid_d  = 1'b0;
    byte_idx_d    = byte_idx_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
`ifdef SHIFT_FRAME_CHECKSUM_EN
    frame_err_d   = frame_err_q;
    xor_d         = byte_valid_q ? (xor_q ^ bus.parallel_data) : xor_q;
`endif
    case (state_q)
      ST_HUNT: begin
        if (bus.serial_valid) begin
          // hunt_cnt==7 guarantees all window bits arrived after the last frame ended
          if (hunt_cnt_q == 3'd7 && window == HEADER) begin
            state_d    = ST_PAYLOAD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            idle_cnt_d = '0;
`ifdef SHIFT_FRAME_CHECKSUM_EN
            xor_d      = '0;
`endif
          end else if (hunt_cnt_q != 3'd7) begin
            hunt_cnt_d = hunt_cnt_q + 3'd1;
          end
        end
      end
      ST_PAYLOAD, ST_CKSUM: begin
        if (bus.serial_valid) begin
          idle_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == ST_PAYLOAD) begin
              byte_valid_d = 1'b1;
              byte_idx_d   = byte_cnt_q;
              byte_cnt_d   = byte_cnt_q + 8'd1;
              if (last_byte) begin
`ifdef SHIFT_FRAME_CHECKSUM_EN
                state_d      = ST_CKSUM;
`else
                frame_done_d = 1'b1;
                state_d      = ST_HUNT;
                hunt_cnt_d   = '0;
`endif
              end
            end else begin
              frame_done_d = 1'b1;
              state_d      = ST_HUNT;
              hunt_cnt_d   = '0;
`ifdef SHIFT_FRAME_CHECKSUM_EN
              frame_err_d  = (xor_q != window);
`endif
            end
          end
        end else if (idle_cnt_q == IW'(TIMEOUT - 1)) begin
          frame_abort_d = 1'b1;
          state_d       = ST_HUNT;
          hunt_cnt_d    = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      hunt_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      byte_valid_q  <= 1'b0;
      byte_idx_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
`ifdef SHIFT_FRAME_CHECKSUM_EN
      xor_q         <= '0;
      frame_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hunt_cnt_q    <= hunt_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      byte_valid_q  <= byte_valid_d;
      byte_idx_q    <= byte_idx_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
`ifdef SHIFT_FRAME_CHECKSUM_EN
      xor_q         <= xor_d;
      frame_err_q   <= frame_err_d;
`endif
    end
  end

  assign bus.shift_ena   = bus.serial_valid;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.byte_idx    = byte_idx_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_abort = frame_abort_q;
  assign bus.busy        = (state_q != ST_HUNT);
  assign bus.state_dbg   = state_q;
`ifdef SHIFT_FRAME_CHECKSUM_EN
  assign bus.frame_err   = frame_err_q;
`else
  assign bus.frame_err   = 1'b0;
`endif
endmodule
